pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator for the drone motor drivers. It is the parametrised successor of the single-channel motor PWM block. It drives NCH motor outputs from one shared period counter. Each channel has a double-buffered (shadow/active) duty register, so a new RPM command takes effect only at a period boundary. An optional slew limiter gives soft-start and bounded RPM changes. It sits between the flight-control RPM command logic and the motor driver pins.

## Interface
- RPM_W, 7: duty/counter width. Period is 2^RPM_W cycles.
- NCH, 4: number of motor channels, 1..16.
- SLEW_STEP, 1: maximum duty change per period per channel. Used only with the slew feature; range 1..2^RPM_W-1.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- arm  in  1  level input. 1 runs the counter and outputs; 0 forces all outputs low.
- set  in  1  single-cycle load strobe.
- set_ch  in  max(1,$clog2(NCH))  target channel for set.
- mot_rpm  in  RPM_W  duty value loaded into the shadow register of set_ch.
- mot_pwm  out  NCH  PWM outputs, registered.
- period_start  out  1  high during phase 0 of every armed period.
- set_err  out  1  one-cycle pulse when set carries set_ch >= NCH.
- ramp_busy  out  NCH  bit i = (active[i] != shadow[i]).

## Operation
- Reset values: mot_pwm=0, period_start=0, set_err=0, ramp_busy=0, shadow[*]=0, active[*]=0, phase=0.
- Phase counter p counts 0..2^RPM_W-1 and wraps to 0. It advances one step per cycle while arm=1.
- mot_pwm[i]=1 in phase p iff p < active[i].
  - High count per period = active[i].
  - 0 gives a constant low output.
  - 2^RPM_W-1 gives high for every phase except the last; 100% duty is unreachable.
- High time is contiguous and left-aligned: all channels rise together in phase 0.
- Load: on an edge with set=1 and set_ch<NCH, shadow[set_ch] <= mot_rpm. Other channels are unchanged.
- Invalid channel: set=1 with set_ch>=NCH leaves every shadow register unchanged and makes set_err=1 for the next cycle.
- Period transfer: on the edge that begins phase 0, active[i] <= next(i).
  - Without slew: next(i) = shadow[i].
- Simultaneous events:
  - A set sampled on the same edge that begins phase 0 is not seen by that transfer. It applies one period later.
  - Back-to-back sets to one channel within a period: the last one wins.
- Disarm (arm sampled 0):
  - On the following cycle mot_pwm=0 and period_start=0.
  - p resets to 0 and active[*] clears to 0. shadow[*] is retained.
  - set is still accepted while disarmed.
- Re-arm: phase 0 begins on the cycle after the first edge that samples arm=1. The transfer occurs on that edge.
- Asynchronous reset mid-period: all outputs go low immediately and all state returns to reset values.

## Timing
- Output latency: phase p appears on mot_pwm one cycle after the edge that sets the counter to p. period_start is aligned with phase 0 on mot_pwm.
- Command latency: from the set edge to first use is 1..2^RPM_W cycles, i.e. at the next transfer edge.
- ramp_busy updates one cycle after the set edge or transfer edge that changes shadow or active.
- No combinational path from any input to any output.

## Configuration
- PWM_SLEW_EN defined (slew limiter on):
  - next(i) = active[i] + min(shadow[i]-active[i], SLEW_STEP) when shadow[i] > active[i].
  - next(i) = active[i] - min(active[i]-shadow[i], SLEW_STEP) when shadow[i] < active[i].
  - Arithmetic uses RPM_W+1 bits and saturates, so it never wraps.
  - Because disarm clears active[*], every arm gives a soft start from 0.
- PWM_SLEW_EN undefined: SLEW_STEP is ignored and active[i] takes shadow[i] in a single transfer. ramp_busy is high only between a set and the next transfer.

## Test plan
- Basic duty: reset, arm=1, set ch0=64. Wait for the second period_start, then count mot_pwm[0] over 128 cycles → 64 highs, high for phases 0..63. Other channels = 0 highs.
- Extremes: ch1=0 → 0 highs and constant low. ch2=127 → 127 highs, low only in phase 127.
- Boundary race: set ch0 = 10 → 20 on the edge that begins phase 0. That period shows 10 highs and the next shows 20. set_err pulses once for set_ch=4 with NCH=4, and no channel changes.
- Slew, PWM_SLEW_EN with SLEW_STEP=16: set ch3=100 from 0 → successive periods give 16,32,48,64,80,96,100 highs, and ramp_busy[3] drops after the 100 transfer. Then set 90 → 90 next period. Without the macro: 100 in the first period.
- Disarm and reset: drop arm during phase 40 with duty 64 → mot_pwm=0 from the next cycle. Re-arm → period_start on the cycle after arm is sampled. Assert resetn=0 mid-period → outputs 0 immediately, and the shadow registers read back 0 (first period shows 0 highs).

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel left-aligned PWM generator with one shared period
// counter and a shadow/active duty register pair per channel. A new command
// written to the shadow register is copied to the active register at a
// period boundary.
// Optional feature macro: PWM_SLEW_EN. When it is defined, each transfer moves
// the active duty at most SLEW_STEP toward the shadow duty. This gives a soft
// start after every arm.
module pwm_multi #(
  parameter int RPM_W     = 7,
  parameter int NCH       = 4,
  parameter int SLEW_STEP = 1,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             arm,
  input  logic             set,
  input  logic [CHW-1:0]   set_ch,
  input  logic [RPM_W-1:0] mot_rpm,
  output logic [NCH-1:0]   mot_pwm,
  output logic             period_start,
  output logic             set_err,
  output logic [NCH-1:0]   ramp_busy
);

  localparam int FULL = 1 << RPM_W;
`ifdef PWM_SLEW_EN
  localparam int STEP_EFF = SLEW_STEP;
`else
  // The step is never smaller than the full duty span, so one transfer always
  // lands exactly on the shadow value.
  localparam int STEP_EFF = (SLEW_STEP > FULL) ? SLEW_STEP : FULL;
`endif
  localparam logic [RPM_W:0]   STEP_L = (RPM_W+1)'((STEP_EFF > FULL) ? FULL : STEP_EFF);
  localparam logic [RPM_W-1:0] P_MAX  = {RPM_W{1'b1}};
  localparam logic [RPM_W-1:0] P_ZERO = {RPM_W{1'b0}};
  localparam logic [RPM_W-1:0] P_ONE  = RPM_W'(1);
  localparam logic [CHW:0]     NCH_L  = (CHW+1)'(NCH);

  // Duty applied at a transfer. It steps toward the shadow value by at most
  // STEP_L. The arithmetic is one bit wider and saturates, so it never wraps.
  function automatic logic [RPM_W-1:0] next_duty(input logic [RPM_W-1:0] act,
                                                 input logic [RPM_W-1:0] shd);
    logic [RPM_W:0] a_w;
    logic [RPM_W:0] s_w;
    logic [RPM_W:0] diff_w;
    logic [RPM_W:0] step_w;
    logic [RPM_W:0] res_w;
    a_w = {1'b0, act};
    s_w = {1'b0, shd};
    if (s_w > a_w) begin
      diff_w = s_w - a_w;
      step_w = (diff_w > STEP_L) ? STEP_L : diff_w;
      res_w  = a_w + step_w;
    end else if (s_w < a_w) begin
      diff_w = a_w - s_w;
      step_w = (diff_w > STEP_L) ? STEP_L : diff_w;
      res_w  = a_w - step_w;
    end else begin
      diff_w = {(RPM_W+1){1'b0}};
      step_w = {(RPM_W+1){1'b0}};
      res_w  = a_w;
    end
    if (res_w[RPM_W]) begin
      return P_MAX;
    end else begin
      return res_w[RPM_W-1:0];
    end
  endfunction

  logic [RPM_W-1:0]          p_q, p_d;
  logic                      armed_q, armed_d;
  logic [NCH-1:0][RPM_W-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][RPM_W-1:0] active_q, active_d;
  logic [NCH-1:0]            pwm_q, pwm_d;
  logic [NCH-1:0]            busy_q, busy_d;
  logic                      ps_q, ps_d;
  logic                      err_q, err_d;
  logic                      wrap_s, xfer_s, set_ok_s;

  // Next-state logic: phase counter, shadow loads, period transfer, outputs.
  always_comb begin
    wrap_s   = armed_q & (p_q == P_MAX);
    // The first armed edge and every wrap edge both begin phase 0.
    xfer_s   = arm & (~armed_q | wrap_s);
    set_ok_s = set & ({1'b0, set_ch} < NCH_L);
    armed_d  = arm;
    err_d    = set & ~set_ok_s;

    if (!arm) begin
      p_d = P_ZERO;
    end else if (!armed_q) begin
      p_d = P_ZERO;
    end else begin
      p_d = p_q + P_ONE;
    end

    ps_d = arm & (p_d == P_ZERO);

    for (int i = 0; i < NCH; i++) begin
      if (set_ok_s && (set_ch == CHW'(i))) begin
        shadow_d[i] = mot_rpm;
      end else begin
        shadow_d[i] = shadow_q[i];
      end

      // The transfer reads the old shadow value, so a set on a boundary edge
      // takes effect one period later.
      if (!arm) begin
        active_d[i] = P_ZERO;
      end else if (xfer_s) begin
        active_d[i] = next_duty(active_q[i], shadow_q[i]);
      end else begin
        active_d[i] = active_q[i];
      end

      pwm_d[i]  = arm & (p_d < active_d[i]);
      busy_d[i] = (active_d[i] != shadow_d[i]);
    end
  end

  // State and registered outputs. The asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_q      <= P_ZERO;
      armed_q  <= 1'b0;
      shadow_q <= {NCH{P_ZERO}};
      active_q <= {NCH{P_ZERO}};
      pwm_q    <= {NCH{1'b0}};
      busy_q   <= {NCH{1'b0}};
      ps_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      p_q      <= p_d;
      armed_q  <= armed_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      busy_q   <= busy_d;
      ps_q     <= ps_d;
      err_q    <= err_d;
    end
  end

  assign mot_pwm      = pwm_q;
  assign ramp_busy    = busy_q;
  assign period_start = ps_q;
  assign set_err      = err_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi. A duty-level reference model tracks the
// commanded (shadow) and applied (active) duties per period. Each test
// compares observed per-period high counts, alignment and flags against that
// model.
module tb_pwm_multi;
  localparam int RPM_W = 7;
  localparam int NCH   = 5;
  localparam int SLEW  = 16;
  localparam int PER   = 128;
  localparam int CHW   = 3;

  logic             clk = 1'b0;
  logic             resetn, arm, set;
  logic [CHW-1:0]   set_ch;
  logic [RPM_W-1:0] mot_rpm;
  logic [NCH-1:0]   mot_pwm, ramp_busy;
  logic             period_start, set_err;

  pwm_multi #(.RPM_W(RPM_W), .NCH(NCH), .SLEW_STEP(SLEW)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .set(set), .set_ch(set_ch),
    .mot_rpm(mot_rpm), .mot_pwm(mot_pwm), .period_start(period_start),
    .set_err(set_err), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sh_m[NCH];
  int act_m[NCH];
  int obs_hi[NCH];
  bit obs_gap[NCH];
  int obs_ps0, obs_ps_other, obs_err;
  logic [NCH-1:0] obs_busy_end;

  function automatic int next_duty(int a, int s);
`ifdef PWM_SLEW_EN
    if (s > a) return a + (((s - a) < SLEW) ? (s - a) : SLEW);
    if (s < a) return a - (((a - s) < SLEW) ? (a - s) : SLEW);
    return a;
`else
    return (a == s) ? a : s;
`endif
  endfunction

  task automatic model_boundary();
    for (int i = 0; i < NCH; i++) act_m[i] = next_duty(act_m[i], sh_m[i]);
  endtask

  function automatic logic [NCH-1:0] busy_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (act_m[i] != sh_m[i]);
    return v;
  endfunction

  // Runs one period starting at the negedge of phase 0 and records observations.
  // It can issue an optional set at phase set_at, or drop arm at phase drop_at.
  task automatic run_period(input int set_at, input int sch, input int sval, input int drop_at);
    bit seen_low[NCH];
    obs_ps0 = 0; obs_ps_other = 0; obs_err = 0;
    for (int i = 0; i < NCH; i++) begin obs_hi[i] = 0; obs_gap[i] = 0; seen_low[i] = 0; end
    for (int k = 0; k < PER; k++) begin
      if (period_start) begin if (k == 0) obs_ps0++; else obs_ps_other++; end
      for (int i = 0; i < NCH; i++) begin
        if (mot_pwm[i]) begin obs_hi[i]++; if (seen_low[i]) obs_gap[i] = 1; end
        else seen_low[i] = 1;
      end
      if (set_err) obs_err++;
      if (k == PER - 1) obs_busy_end = ramp_busy;
      set = (k == set_at);
      set_ch = sch[CHW-1:0];
      mot_rpm = sval[RPM_W-1:0];
      if (k == drop_at) arm = 1'b0;
      @(negedge clk);
      if (k == drop_at) begin set = 1'b0; return; end
    end
    set = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; arm = 1'b0; set = 1'b0; set_ch = '0; mot_rpm = '0;
    for (int i = 0; i < NCH; i++) begin sh_m[i] = 0; act_m[i] = 0; end
    repeat (3) @(negedge clk);
    checks++;
    if ({mot_pwm, ramp_busy, period_start, set_err} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {mot_pwm, ramp_busy, period_start, set_err});
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mot_pwm, period_start} !== '0) begin
      errors++; $display("FAIL disarmed_idle got %h want 0", {mot_pwm, period_start});
    end
  endtask

  task automatic test_basic_duty();
    arm = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL arm_period_start got %b want 1", period_start); end
    model_boundary();
    run_period(5, 0, 64, -1);
    sh_m[0] = 64;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_hi[i] !== 0) begin errors++; $display("FAIL basic_first ch%0d highs %0d want 0", i, obs_hi[i]); end
    end
    checks++;
    if (obs_busy_end !== busy_vec()) begin errors++; $display("FAIL basic_busy got %b want %b", obs_busy_end, busy_vec()); end
    model_boundary();
    run_period(-1, 0, 0, -1);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_hi[i] !== act_m[i] || obs_gap[i]) begin
        errors++; $display("FAIL basic_duty ch%0d highs %0d gap %0d want %0d", i, obs_hi[i], obs_gap[i], act_m[i]);
      end
    end
    checks++;
    if (obs_ps0 !== 1 || obs_ps_other !== 0) begin
      errors++; $display("FAIL basic_ps ps0 %0d other %0d want 1 0", obs_ps0, obs_ps_other);
    end
  endtask

  task automatic test_extremes();
    model_boundary();
    run_period(10, 2, 127, -1);
    sh_m[2] = 127;
    model_boundary();
    run_period(3, 1, 0, -1);
    sh_m[1] = 0;
    for (int p = 0; p < 9; p++) begin
      model_boundary();
      run_period(-1, 0, 0, -1);
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (obs_hi[i] !== act_m[i] || obs_gap[i]) begin
          errors++; $display("FAIL extremes p%0d ch%0d highs %0d gap %0d want %0d", p, i, obs_hi[i], obs_gap[i], act_m[i]);
        end
      end
    end
  endtask

  task automatic test_boundary_race();
    model_boundary();
    run_period(20, 0, 10, -1);
    sh_m[0] = 10;
    repeat (4) begin model_boundary(); run_period(-1, 0, 0, -1); end
    model_boundary();
    run_period(PER - 1, 0, 20, -1);
    checks++;
    if (obs_hi[0] !== 10) begin errors++; $display("FAIL race_before highs %0d want 10", obs_hi[0]); end
    model_boundary();
    sh_m[0] = 20;
    run_period(40, 5, 99, -1);
    checks++;
    if (obs_hi[0] !== act_m[0]) begin errors++; $display("FAIL race_same_period highs %0d want %0d", obs_hi[0], act_m[0]); end
    checks++;
    if (obs_err !== 1) begin errors++; $display("FAIL set_err_pulse count %0d want 1", obs_err); end
    checks++;
    if (obs_busy_end !== busy_vec()) begin errors++; $display("FAIL race_busy got %b want %b", obs_busy_end, busy_vec()); end
    model_boundary();
    run_period(-1, 0, 0, -1);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_hi[i] !== act_m[i]) begin errors++; $display("FAIL race_after ch%0d highs %0d want %0d", i, obs_hi[i], act_m[i]); end
    end
  endtask

  task automatic test_slew();
    model_boundary();
    run_period(30, 3, 100, -1);
    sh_m[3] = 100;
    for (int p = 0; p < 8; p++) begin
      model_boundary();
      run_period(-1, 0, 0, -1);
      checks++;
      if (obs_hi[3] !== act_m[3] || obs_busy_end !== busy_vec()) begin
        errors++; $display("FAIL slew_up p%0d highs %0d busy %b want %0d %b", p, obs_hi[3], obs_busy_end, act_m[3], busy_vec());
      end
    end
    model_boundary();
    run_period(50, 3, 90, -1);
    sh_m[3] = 90;
    model_boundary();
    run_period(-1, 0, 0, -1);
    checks++;
    if (obs_hi[3] !== act_m[3] || obs_busy_end[3] !== 1'b0) begin
      errors++; $display("FAIL slew_down highs %0d busy %b want %0d 0", obs_hi[3], obs_busy_end[3], act_m[3]);
    end
  endtask

  task automatic test_disarm();
    model_boundary();
    run_period(10, 0, 64, -1);
    sh_m[0] = 64;
    repeat (5) begin model_boundary(); run_period(-1, 0, 0, -1); end
    model_boundary();
    run_period(-1, 0, 0, 40);
    for (int i = 0; i < NCH; i++) act_m[i] = 0;
    checks++;
    if (mot_pwm !== '0 || period_start !== 1'b0) begin
      errors++; $display("FAIL disarm_outputs pwm %b ps %b want 0 0", mot_pwm, period_start);
    end
    set = 1'b1; set_ch = 3'd1; mot_rpm = 7'd33;
    @(negedge clk);
    set = 1'b0;
    sh_m[1] = 33;
    repeat (2) @(negedge clk);
    checks++;
    if (mot_pwm !== '0 || ramp_busy !== busy_vec()) begin
      errors++; $display("FAIL disarmed_set pwm %b busy %b want 0 %b", mot_pwm, ramp_busy, busy_vec());
    end
    arm = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL rearm_ps got %b want 1", period_start); end
    model_boundary();
    run_period(-1, 0, 0, -1);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_hi[i] !== act_m[i]) begin errors++; $display("FAIL rearm ch%0d highs %0d want %0d", i, obs_hi[i], act_m[i]); end
    end
  endtask

  task automatic test_random();
    int ch, val, ph;
    for (int p = 0; p < 6; p++) begin
      ch = int'($urandom_range(0, 7));
      val = int'($urandom_range(0, 127));
      ph = int'($urandom_range(1, 120));
      model_boundary();
      run_period(ph, ch, val, -1);
      if (ch < NCH) sh_m[ch] = val;
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (obs_hi[i] !== act_m[i] || obs_gap[i]) begin
          errors++; $display("FAIL random p%0d ch%0d highs %0d gap %0d want %0d", p, i, obs_hi[i], obs_gap[i], act_m[i]);
        end
      end
      checks++;
      if (obs_err !== ((ch >= NCH) ? 1 : 0) || obs_busy_end !== busy_vec()) begin
        errors++; $display("FAIL random_flags p%0d err %0d busy %b want %0d %b", p, obs_err, obs_busy_end, (ch >= NCH), busy_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (30) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({mot_pwm, ramp_busy, period_start, set_err} !== '0) begin
      errors++; $display("FAIL async_reset got %h want 0", {mot_pwm, ramp_busy, period_start, set_err});
    end
    for (int i = 0; i < NCH; i++) begin sh_m[i] = 0; act_m[i] = 0; end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL reset_rearm_ps got %b want 1", period_start); end
    model_boundary();
    run_period(-1, 0, 0, -1);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (obs_hi[i] !== 0) begin errors++; $display("FAIL reset_shadow ch%0d highs %0d want 0", i, obs_hi[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_extremes();
    test_boundary_race();
    test_slew();
    test_disarm();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
